// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage.
package writeback_stage_pkg;

    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_REG_COUNT  = 32;
    localparam int unsigned WB_ADDR_WIDTH = $clog2(WB_REG_COUNT);

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_if.sv
// Aux-unit handshake plus register-file write and forwarding buses of the writeback stage.
interface writeback_stage_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  aux_valid_i;
    logic [ADDR_WIDTH-1:0] aux_rd_i;
    logic [DATA_WIDTH-1:0] aux_data_i;
    logic                  aux_ready_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] wr_addr_o;
    logic [DATA_WIDTH-1:0] wr_data_o;
    logic                  fwd_valid_o;
    logic [ADDR_WIDTH-1:0] fwd_addr_o;
    logic [DATA_WIDTH-1:0] fwd_data_o;

    modport slave (
        input  aux_valid_i, aux_rd_i, aux_data_i,
        output aux_ready_o, we_o, wr_addr_o, wr_data_o,
        output fwd_valid_o, fwd_addr_o, fwd_data_o
    );

    modport master (
        output aux_valid_i, aux_rd_i, aux_data_i,
        input  aux_ready_o, we_o, wr_addr_o, wr_data_o,
        input  fwd_valid_o, fwd_addr_o, fwd_data_o
    );
endinterface

// File: rtl/writeback_stage_load_extend.sv
// Combinational byte/half selection and sign/zero extension of a raw load word.
module load_extend
    import writeback_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            lsb_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{lsb_i, 3'b000} +: 8];
        half_v = rdata_i[{lsb_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_LB:   data_o = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            F3_LH:   data_o = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, result select, write-port arbitration with an aux unit.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
    parameter int unsigned REG_COUNT  = WB_REG_COUNT,
    parameter int unsigned ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  wb_valid_i,
    input  logic                  wb_reg_write_i,
    input  logic [ADDR_WIDTH-1:0] wb_rd_i,
    input  logic [1:0]            wb_sel_i,
    input  logic [2:0]            wb_funct3_i,
    input  logic [1:0]            wb_addr_lsb_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic [DATA_WIDTH-1:0] pc_plus4_i,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]           retire_cnt_o,
`endif
    writeback_stage_if.slave      bus
);

    logic                  valid_q, valid_d;
    logic                  reg_write_q, reg_write_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [1:0]            sel_q, sel_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            lsb_q, lsb_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
    logic                  written_q, written_d;

    logic                  pipe_we;
    logic                  aux_fire;
    logic                  aux_we;
    logic                  we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] pipe_data;

    load_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extend (
        .funct3_i (funct3_q),
        .lsb_i    (lsb_q),
        .rdata_i  (mem_rdata_q),
        .data_o   (load_data)
    );

    // written_q remembers that a stalled instruction already used the port.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        sel_d       = sel_q;
        funct3_d    = funct3_q;
        lsb_d       = lsb_q;
        alu_d       = alu_q;
        mem_rdata_d = mem_rdata_q;
        pc4_d       = pc4_q;
        written_d   = written_q;
        if (flush_i) begin
            valid_d   = 1'b0;
            written_d = 1'b0;
        end else if (stall_i) begin
            written_d = written_q | pipe_we;
        end else begin
            valid_d     = wb_valid_i;
            reg_write_d = wb_reg_write_i;
            rd_d        = wb_rd_i;
            sel_d       = wb_sel_i;
            funct3_d    = wb_funct3_i;
            lsb_d       = wb_addr_lsb_i;
            alu_d       = alu_result_i;
            mem_rdata_d = mem_rdata_i;
            pc4_d       = pc_plus4_i;
            written_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            sel_q       <= '0;
            funct3_q    <= '0;
            lsb_q       <= '0;
            alu_q       <= '0;
            mem_rdata_q <= '0;
            pc4_q       <= '0;
            written_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            sel_q       <= sel_d;
            funct3_q    <= funct3_d;
            lsb_q       <= lsb_d;
            alu_q       <= alu_d;
            mem_rdata_q <= mem_rdata_d;
            pc4_q       <= pc4_d;
            written_q   <= written_d;
        end
    end

    always_comb begin
        case (sel_q)
            WB_MEM:  pipe_data = load_data;
            WB_PC4:  pipe_data = pc4_q;
            default: pipe_data = alu_q;
        endcase
    end

    // Aux is never accepted while reset is asserted, even though ready reads 1.
    always_comb begin
        pipe_we  = valid_q & reg_write_q & (rd_q != '0) & ~written_q;
        aux_fire = bus.aux_valid_i & ~pipe_we & rst_n;
        aux_we   = aux_fire & (bus.aux_rd_i != '0);
        we       = pipe_we | aux_we;
        wr_addr  = '0;
        wr_data  = '0;
        if (pipe_we) begin
            wr_addr = rd_q;
            wr_data = pipe_data;
        end else if (aux_we) begin
            wr_addr = bus.aux_rd_i;
            wr_data = bus.aux_data_i;
        end
    end

    assign bus.aux_ready_o = ~pipe_we;
    assign bus.we_o        = we;
    assign bus.wr_addr_o   = wr_addr;
    assign bus.wr_data_o   = wr_data;
    assign bus.fwd_valid_o = we;
    assign bus.fwd_addr_o  = wr_addr;
    assign bus.fwd_data_o  = wr_data;

`ifdef WB_RETIRE_CNT_EN
    logic        counted_q, counted_d;
    logic [63:0] retire_cnt_q, retire_cnt_d;

    // counted_q covers held instructions that never write and so never set written_q.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (valid_q & ~written_q & ~counted_q) begin
            retire_cnt_d = retire_cnt_q + 64'd1;
        end
        if (flush_i) begin
            counted_d = 1'b0;
        end else if (stall_i) begin
            counted_d = counted_q | valid_q;
        end else begin
            counted_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counted_q    <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            counted_q    <= counted_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a cycle-level reference model and literal spot checks.
module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        wb_valid_i;
    logic        wb_reg_write_i;
    logic [4:0]  wb_rd_i;
    logic [1:0]  wb_sel_i;
    logic [2:0]  wb_funct3_i;
    logic [1:0]  wb_addr_lsb_i;
    logic [31:0] alu_result_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] pc_plus4_i;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    writeback_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    writeback_stage #(
        .DATA_WIDTH (32),
        .REG_COUNT  (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .wb_valid_i     (wb_valid_i),
        .wb_reg_write_i (wb_reg_write_i),
        .wb_rd_i        (wb_rd_i),
        .wb_sel_i       (wb_sel_i),
        .wb_funct3_i    (wb_funct3_i),
        .wb_addr_lsb_i  (wb_addr_lsb_i),
        .alu_result_i   (alu_result_i),
        .mem_rdata_i    (mem_rdata_i),
        .pc_plus4_i     (pc_plus4_i),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt_o   (retire_cnt_o),
`endif
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the instruction sitting in writeback, as plain fields.
    logic        m_valid = 0, m_rw = 0, m_done = 0, m_counted = 0;
    logic [4:0]  m_rd = 0;
    logic [1:0]  m_sel = 0, m_lsb = 0;
    logic [2:0]  m_f3 = 0;
    logic [31:0] m_alu = 0, m_mem = 0, m_pc4 = 0;
    logic [63:0] m_cnt = 0;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lsb, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * lsb);
        case (f3)
            3'b000:  return 32'($signed(sh[7:0]));
            3'b100:  return sh & 32'hFF;
            3'b001:  return 32'($signed(16'(w >> (16 * lsb[1]))));
            3'b101:  return (w >> (16 * lsb[1])) & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic logic ref_pipe_we();
        return m_valid && m_rw && (m_rd != 0) && !m_done;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_rw = 0; m_done = 0; m_counted = 0; m_rd = 0;
            m_sel = 0; m_lsb = 0; m_f3 = 0; m_alu = 0; m_mem = 0; m_pc4 = 0; m_cnt = 0;
        end else begin
            logic pipe;
            pipe = ref_pipe_we();
            if (m_valid && !m_counted && !m_done) m_cnt = m_cnt + 1;
            if (flush_i) begin
                m_valid = 0; m_done = 0; m_counted = 0;
            end else if (stall_i) begin
                m_done    = m_done || pipe;
                m_counted = m_counted || m_valid;
            end else begin
                m_valid = wb_valid_i; m_rw = wb_reg_write_i; m_rd = wb_rd_i;
                m_sel = wb_sel_i; m_f3 = wb_funct3_i; m_lsb = wb_addr_lsb_i;
                m_alu = alu_result_i; m_mem = mem_rdata_i; m_pc4 = pc_plus4_i;
                m_done = 0; m_counted = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic        pipe, aux_ok, e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        pipe   = ref_pipe_we();
        aux_ok = bus.aux_valid_i && !pipe && rst_n;
        e_we   = pipe || (aux_ok && bus.aux_rd_i != 0);
        e_addr = 0;
        e_data = 0;
        if (pipe) begin
            e_addr = m_rd;
            e_data = (m_sel == 2'b01) ? ref_load(m_f3, m_lsb, m_mem) :
                     (m_sel == 2'b10) ? m_pc4 : m_alu;
        end else if (e_we) begin
            e_addr = bus.aux_rd_i;
            e_data = bus.aux_data_i;
        end
        chk("m_we",        64'(bus.we_o),        64'(e_we));
        chk("m_addr",      64'(bus.wr_addr_o),   64'(e_addr));
        chk("m_data",      64'(bus.wr_data_o),   64'(e_data));
        chk("m_ready",     64'(bus.aux_ready_o), 64'(!pipe));
        chk("m_fwd_valid", 64'(bus.fwd_valid_o), 64'(e_we));
        chk("m_fwd_addr",  64'(bus.fwd_addr_o),  64'(e_addr));
        chk("m_fwd_data",  64'(bus.fwd_data_o),  64'(e_data));
`ifdef WB_RETIRE_CNT_EN
        chk("m_retire",    retire_cnt_o,         m_cnt);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [1:0] lsb,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4);
        wb_valid_i = 1; wb_reg_write_i = rw; wb_rd_i = rd; wb_sel_i = sel;
        wb_funct3_i = f3; wb_addr_lsb_i = lsb;
        alu_result_i = alu; mem_rdata_i = mem; pc_plus4_i = pc4;
    endtask

    task automatic idle();
        wb_valid_i = 0; wb_reg_write_i = 0;
    endtask

    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_lsb [5] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFFFFF3, 32'h00000080, 32'hFFFF8081, 32'h0000F2F3, 32'h8081F2F3};

    initial begin
        int pulses;
        rst_n = 0; stall_i = 0; flush_i = 0;
        wb_valid_i = 0; wb_reg_write_i = 0; wb_rd_i = 0; wb_sel_i = 0;
        wb_funct3_i = 0; wb_addr_lsb_i = 0;
        alu_result_i = 0; mem_rdata_i = 0; pc_plus4_i = 0;
        bus.aux_valid_i = 0; bus.aux_rd_i = 0; bus.aux_data_i = 0;
        step(); step();
        chk("rst_we", 64'(bus.we_o), 64'd0);
        chk("rst_data", 64'(bus.wr_data_o), 64'd0);
        chk("rst_ready", 64'(bus.aux_ready_o), 64'd1);
        rst_n = 1;
        step();

        issue(1, 5'd5, 2'b00, 3'b000, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0);
        step(); idle();
        chk("alu_we", 64'(bus.we_o), 64'd1);
        chk("alu_addr", 64'(bus.wr_addr_o), 64'd5);
        chk("alu_data", 64'(bus.wr_data_o), 64'hDEADBEEF);
        chk("alu_fwd_data", 64'(bus.fwd_data_o), 64'hDEADBEEF);
        step();
        chk("alu_we_next", 64'(bus.we_o), 64'd0);

        for (int i = 0; i < 5; i++) begin
            issue(1, 5'd2, 2'b01, ld_f3[i], ld_lsb[i], 32'h0, 32'h8081F2F3, 32'h0);
            step(); idle();
            chk($sformatf("load%0d", i), 64'(bus.wr_data_o), 64'(ld_exp[i]));
        end
        issue(1, 5'd1, 2'b10, 3'b000, 2'd0, 32'h5, 32'h0, 32'h104);
        step(); idle();
        chk("pc4_data", 64'(bus.wr_data_o), 64'h104);
        issue(1, 5'd4, 2'b11, 3'b000, 2'd0, 32'h77, 32'h0, 32'h104);
        step(); idle();
        chk("sel11_data", 64'(bus.wr_data_o), 64'h77);

        issue(1, 5'd0, 2'b00, 3'b000, 2'd0, 32'hBAD0BAD0, 32'h0, 32'h0);
        step(); idle();
        chk("rd0_we", 64'(bus.we_o), 64'd0);
        chk("rd0_ready", 64'(bus.aux_ready_o), 64'd1);
        step();

        issue(1, 5'd10, 2'b00, 3'b000, 2'd0, 32'hA0A0, 32'h0, 32'h0);
        bus.aux_valid_i = 1; bus.aux_rd_i = 5'd7; bus.aux_data_i = 32'h1234;
        step(); idle();
        chk("conf1_addr", 64'(bus.wr_addr_o), 64'd10);
        chk("conf1_ready", 64'(bus.aux_ready_o), 64'd0);
        step();
        chk("conf2_we", 64'(bus.we_o), 64'd1);
        chk("conf2_addr", 64'(bus.wr_addr_o), 64'd7);
        chk("conf2_data", 64'(bus.wr_data_o), 64'h1234);
        chk("conf2_ready", 64'(bus.aux_ready_o), 64'd1);
        step();
        bus.aux_valid_i = 0;

        issue(1, 5'd3, 2'b00, 3'b000, 2'd0, 32'h333, 32'h0, 32'h0);
        step(); idle();
        stall_i = 1;
        bus.aux_valid_i = 1; bus.aux_rd_i = 5'd9; bus.aux_data_i = 32'h99;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) bus.aux_valid_i = 0;
            #1;
            if (bus.we_o && bus.wr_addr_o == 5'd3) pulses++;
            if (k == 1) begin
                chk("stall_aux_addr", 64'(bus.wr_addr_o), 64'd9);
                chk("stall_aux_ready", 64'(bus.aux_ready_o), 64'd1);
            end
            step();
        end
        chk("stall_pulses", 64'(pulses), 64'd1);
        issue(1, 5'd4, 2'b00, 3'b000, 2'd0, 32'h444, 32'h0, 32'h0);
        flush_i = 1;
        step();
        flush_i = 0; stall_i = 0; idle();
        chk("flush_we", 64'(bus.we_o), 64'd0);
        step();
        chk("flush_we2", 64'(bus.we_o), 64'd0);

        issue(1, 5'd6, 2'b00, 3'b000, 2'd0, 32'h66, 32'h0, 32'h0);
        step(); idle();
        rst_n = 0;
        bus.aux_valid_i = 1; bus.aux_rd_i = 5'd8; bus.aux_data_i = 32'h88;
        #1;
        chk("midrst_we", 64'(bus.we_o), 64'd0);
        step();
        bus.aux_valid_i = 0;
        rst_n = 1;
        step();

`ifdef WB_RETIRE_CNT_EN
        for (int i = 0; i < 15; i++) begin
            issue((i % 3) != 0, 5'(i + 1), 2'b00, 3'b000, 2'd0, 32'(i), 32'h0, 32'h0);
            if (i == 7) begin
                stall_i = 1;
                step(); step();
                stall_i = 0;
            end
            step();
        end
        idle();
        step();
        chk("retire15", retire_cnt_o, 64'd15);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage and the sole writer of the register file write port (`we`, `wr_addr`, `wr_data`).
- Captures MEM/WB results in a pipeline register and selects the writeback value from ALU result, aligned/extended load data, or PC+4.
- Arbitrates the single write port between the pipeline and an auxiliary multi-cycle unit (divider), which uses a valid/ready handshake.
- Mirrors the committed write on a forwarding bus for the decode-stage bypass.

Parameters:
- DATA_WIDTH, 32, register and data width.
- REG_COUNT, 32, number of architectural registers.
- ADDR_WIDTH, $clog2(REG_COUNT), register address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold the stage register
- flush_i  in  1  invalidate the captured instruction
- wb_valid_i  in  1  MEM stage presents an instruction
- wb_reg_write_i  in  1  instruction writes rd
- wb_rd_i  in  ADDR_WIDTH  destination register
- wb_sel_i  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
- wb_funct3_i  in  3  load type
- wb_addr_lsb_i  in  2  load byte offset
- alu_result_i  in  DATA_WIDTH  ALU result
- mem_rdata_i  in  DATA_WIDTH  raw load word
- pc_plus4_i  in  DATA_WIDTH  link value
- aux_valid_i  in  1  auxiliary result valid
- aux_rd_i  in  ADDR_WIDTH  auxiliary destination
- aux_data_i  in  DATA_WIDTH  auxiliary result
- aux_ready_o  out  1  auxiliary result accepted this cycle
- we_o  out  1  register file write enable
- wr_addr_o  out  ADDR_WIDTH  register file write address
- wr_data_o  out  DATA_WIDTH  register file write data
- fwd_valid_o  out  1  forwarding valid (equal to we_o)
- fwd_addr_o  out  ADDR_WIDTH  forwarding address
- fwd_data_o  out  DATA_WIDTH  forwarding data

Behaviour:
- Reset:
  - All stage registers and the `written_q` flag clear.
  - Outputs reset to: `we_o` = 0, `wr_addr_o` = 0, `wr_data_o` = 0, `fwd_*` = 0, `aux_ready_o` = 1.
- Capture:
  - At posedge with `stall_i` = 0, all `wb_*` inputs and data inputs are latched and `written_q` clears.
  - `flush_i` = 1 clears `valid_q` and takes priority over both capture and stall.
  - With `stall_i` = 1, the stage holds.
- Pipeline write request:
  - `pipe_we` = `valid_q` & `reg_write_q` & (`rd_q` != 0) & ~`written_q`.
  - If `pipe_we` and `stall_i`, `written_q` is set at the next edge, so a held instruction writes exactly once.
- Latency: inputs captured at edge N; `we_o` is high in cycle N..N+1; the register file commits at edge N+1.
- Port arbitration, pipeline has priority:
  - `aux_ready_o` = ~`pipe_we`.
  - Aux transfer occurs when `aux_valid_i` & `aux_ready_o`.
  - An aux transfer with `aux_rd_i` = 0 is accepted but `we_o` stays 0.
  - Aux holds its data stable while not ready.
- Write port: `we_o` = `pipe_we` | (aux transfer & `aux_rd_i` != 0); address and data come from the winning source, and are 0 when `we_o` = 0. The port is combinational from the stage register and aux inputs.
- Load extraction:
  - byte = `mem_rdata_q[lsb*8 +: 8]`; half = `mem_rdata_q[lsb[1]*16 +: 16]`.
  - funct3 000 LB sign-extend byte; 100 LBU zero-extend byte; 001 LH sign-extend half; 101 LHU zero-extend half; 010 LW full word.
  - Any other funct3 is treated as LW.
- Register 0 is never written by either source.
- Forwarding: `fwd_valid_o`, `fwd_addr_o`, `fwd_data_o` equal `we_o`, `wr_addr_o`, `wr_data_o` in the same cycle.
- Reset mid-operation: the captured instruction is lost and there is no write; an aux transfer in flight is not accepted.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Adds output `retire_cnt_o` [63:0], reset 0.
  - Increments once per retired instruction: `valid_q` & ~`written_q` in a cycle where the instruction has not yet been counted (counted on its first cycle only, including non-writing instructions and rd = 0).
  - Not incremented by aux transfers.
  - Wraps at 2^64.
- When not defined: the port and the counter are absent.

Decomposition:
- Shared package:
  - `wb_sel_e` enum (`WB_ALU`, `WB_MEM`, `WB_PC4`).
  - `funct3` load constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`).
  - DATA_WIDTH / ADDR_WIDTH constants.
- Sub-module: `load_extend` (combinational byte/half select and extension), instantiated once.

Test Plan:
- Reset then ALU op: `wb_sel` = 00, rd = 5, alu = 0xDEADBEEF, captured at edge N → `we_o` = 1, `wr_addr_o` = 5, `wr_data_o` = 0xDEADBEEF in cycle N; `fwd` bus identical; `we_o` = 0 the next cycle.
- Loads with `mem_rdata` = 0x8081F2F3:
  - LB lsb = 0 → 0xFFFFFFF3
  - LBU lsb = 3 → 0x00000080
  - LH lsb = 2 → 0xFFFF8081
  - LHU lsb = 0 → 0x0000F2F3
  - LW → 0x8081F2F3
- rd = 0 with `reg_write` = 1 and alu = 0xBAD0BAD0 → `we_o` stays 0; `aux_ready_o` stays 1.
- Conflict: pipeline write rd = 10 while `aux_valid_i` = 1 (rd = 7, data = 0x1234) → cycle 1 writes reg 10 with `aux_ready_o` = 0; cycle 2 writes reg 7 = 0x1234 with `aux_ready_o` = 1.
- `stall_i` held 3 cycles after capturing rd = 3 → exactly one `we_o` pulse; aux is granted in the remaining stall cycles; `flush_i` during the stall cancels a not-yet-captured instruction.
- WB_RETIRE_CNT_EN: 15 sequential instructions with one 2-cycle stall → `retire_cnt_o` = 15.
